// File: rtl/axis_decimator_pkg.sv
// Shared definitions for the multi-channel AXI4-Stream decimator:
// reduction mode encodings and the shift/saturate range helper.
package axis_decimator_pkg;

    localparam logic [1:0] MODE_SAMPLE = 2'd0;
    localparam logic [1:0] MODE_ACCUM  = 2'd1;
    localparam logic [1:0] MODE_MAX    = 2'd2;

    // Arithmetic-shifts val and reports whether the result falls outside a
    // signed range of the given width: {above_max, below_min}.
    function automatic logic [1:0] sat_flags(input logic signed [63:0] val,
                                             input logic [7:0]          shift,
                                             input int unsigned         width);
        logic signed [63:0] shifted;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        shifted   = val >>> shift;
        hi        = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo        = -(64'sd1 <<< (width - 1));
        sat_flags = {shifted > hi, shifted < lo};
    endfunction

endpackage

// File: rtl/axis_decimator_lane.sv
// Single-channel reduction lane: keeps the running sample/sum/max for one
// channel and forms the frame result for the beat being accepted.
module axis_decimator_lane
    import axis_decimator_pkg::*;
#(
    parameter int CHAN_WIDTH  = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   beat_en,
    input  logic                   first,
    input  logic [1:0]             mode,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic [CHAN_WIDTH-1:0]  sample,
    output logic [CHAN_WIDTH-1:0]  result
);

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] smp_ext;
    logic signed [ACC_WIDTH-1:0] nxt;
    logic [1:0]                  flags;

    assign smp_ext = {{(ACC_WIDTH-CHAN_WIDTH){sample[CHAN_WIDTH-1]}}, sample};

    // nxt already includes the current beat, so the result is valid on the
    // same beat that closes the frame.
    always_comb begin
        nxt = smp_ext;
        if (!first) begin
            if (mode == MODE_ACCUM) begin
                nxt = acc_q + smp_ext;
            end else if (mode == MODE_MAX && acc_q > smp_ext) begin
                nxt = acc_q;
            end
        end
        acc_d = beat_en ? nxt : acc_q;
        flags = sat_flags(64'(nxt), 8'(shift), CHAN_WIDTH);

        result = CHAN_WIDTH'(nxt);
        if (mode == MODE_ACCUM) begin
            if (flags[1]) begin
                result = {1'b0, {(CHAN_WIDTH-1){1'b1}}};
            end else if (flags[0]) begin
                result = {1'b1, {(CHAN_WIDTH-1){1'b0}}};
            end else begin
                result = CHAN_WIDTH'(nxt >>> shift);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/axis_decimator_multi.sv
// Multi-channel AXI4-Stream decimator: frame counter, per-frame config latch,
// backpressure-aware output register and frame statistics around NCH lanes.
module axis_decimator_multi
    import axis_decimator_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int CHAN_WIDTH  = 16,
    parameter int CNTR_WIDTH  = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [CNTR_WIDTH-1:0]     cfg_data,
    input  logic [1:0]                cfg_mode,
    input  logic [SHIFT_WIDTH-1:0]    cfg_shift,
    output logic                      s_axis_tready,
    input  logic [NCH*CHAN_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [NCH*CHAN_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic [31:0]               sts_frames
);

    logic                      run_q;
    logic [CNTR_WIDTH-1:0]     cnt_q,   cnt_d;
    logic [CNTR_WIDTH-1:0]     ratio_q, ratio_d;
    logic [1:0]                mode_q,  mode_d;
    logic [SHIFT_WIDTH-1:0]    shift_q, shift_d;
    logic                      m_valid_q, m_valid_d;
    logic [NCH*CHAN_WIDTH-1:0] m_data_q,  m_data_d;
    logic [31:0]               sts_q,   sts_d;

    logic                      accept;
    logic                      first;
    logic                      last;
    logic [CNTR_WIDTH-1:0]     ratio_eff;
    logic [1:0]                mode_eff;
    logic [SHIFT_WIDTH-1:0]    shift_eff;
    logic [NCH*CHAN_WIDTH-1:0] lane_res;

    assign s_axis_tready = run_q & (~m_valid_q | m_axis_tready);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign first         = (cnt_q == '0);

    // The opening beat of a frame uses the live config, which is latched
    // for the remaining beats.
    assign ratio_eff = first ? cfg_data  : ratio_q;
    assign mode_eff  = first ? cfg_mode  : mode_q;
    assign shift_eff = first ? cfg_shift : shift_q;
    assign last      = accept & (cnt_q == ratio_eff);

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        axis_decimator_lane #(
            .CHAN_WIDTH (CHAN_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .SHIFT_WIDTH(SHIFT_WIDTH)
        ) u_lane (
            .aclk   (aclk),
            .aresetn(aresetn),
            .beat_en(accept),
            .first  (first),
            .mode   (mode_eff),
            .shift  (shift_eff),
            .sample (s_axis_tdata[g*CHAN_WIDTH +: CHAN_WIDTH]),
            .result (lane_res[g*CHAN_WIDTH +: CHAN_WIDTH])
        );
    end

    always_comb begin
        cnt_d     = cnt_q;
        ratio_d   = ratio_q;
        mode_d    = mode_q;
        shift_d   = shift_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        sts_d     = sts_q;
        if (accept) begin
            cnt_d = last ? '0 : cnt_q + CNTR_WIDTH'(1);
            if (first) begin
                ratio_d = cfg_data;
                mode_d  = cfg_mode;
                shift_d = cfg_shift;
            end
        end
        if (m_valid_q && m_axis_tready) begin
            m_valid_d = 1'b0;
            sts_d     = sts_q + 32'd1;
        end
        // A new result may land in the same cycle the old one drains.
        if (last) begin
            m_valid_d = 1'b1;
            m_data_d  = lane_res;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run_q     <= 1'b0;
            cnt_q     <= '0;
            ratio_q   <= '0;
            mode_q    <= '0;
            shift_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            sts_q     <= '0;
        end else begin
            run_q     <= 1'b1;
            cnt_q     <= cnt_d;
            ratio_q   <= ratio_d;
            mode_q    <= mode_d;
            shift_q   <= shift_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            sts_q     <= sts_d;
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign sts_frames    = sts_q;

endmodule

// File: tb/tb_axis_decimator_multi.sv
// Directed bench for axis_decimator_multi (NCH=2, 16-bit channels) with
// hand-computed expected frames for each reduction mode and handshake case.
module tb_axis_decimator_multi;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] cfg_data = '0;
    logic [1:0]  cfg_mode = '0;
    logic [4:0]  cfg_shift = '0;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        m_axis_tready = 1'b1;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic [31:0] sts_frames;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          exp_frames = 0;
    logic [31:0] out_q[$];
    int          out_t[$];

    axis_decimator_multi dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .cfg_data     (cfg_data),
        .cfg_mode     (cfg_mode),
        .cfg_shift    (cfg_shift),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .sts_frames   (sts_frames)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            out_q.push_back(m_axis_tdata);
            out_t.push_back(cyc);
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Presents one beat and returns 1 ns after the edge that accepted it.
    task automatic send(input logic [15:0] d0, input logic [15:0] d1, output int stalls);
        int t;
        s_axis_tdata  = {d1, d0};
        s_axis_tvalid = 1'b1;
        t = 0;
        @(negedge aclk);
        while (!s_axis_tready && t < 50) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: tready stayed %0b, required 1", s_axis_tready);
        end
        stalls = t;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        step(2);
        n_cmp += 4;
        if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid: got %0b want 0", m_axis_tvalid); end
        if (m_axis_tdata !== 32'd0) begin n_bad++; $display("FAIL rst_tdata: got %h want 0", m_axis_tdata); end
        if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL rst_tready: got %0b want 0", s_axis_tready); end
        if (sts_frames !== 32'd0) begin n_bad++; $display("FAIL rst_sts: got %0d want 0", sts_frames); end
        aresetn = 1'b1;
        @(negedge aclk);
        n_cmp++;
        if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL rel_tready_early: got %0b want 0", s_axis_tready); end
        @(posedge aclk);
        #1;
        n_cmp++;
        if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL rel_tready: got %0b want 1", s_axis_tready); end
    endtask

    task automatic test_sample();
        int st;
        int st_total;
        cfg_data = 16'd3; cfg_mode = 2'd0; cfg_shift = 5'd0; m_axis_tready = 1'b1;
        out_q.delete(); out_t.delete();
        st_total = 0;
        for (int i = 1; i <= 8; i++) begin
            send(16'(i), 16'(100 + i), st);
            st_total += st;
            if (i == 4) begin
                n_cmp += 2;
                if (m_axis_tvalid !== 1'b1) begin n_bad++; $display("FAIL smp_latency_valid: got %0b want 1", m_axis_tvalid); end
                if (m_axis_tdata !== {16'd104, 16'd4}) begin n_bad++; $display("FAIL smp_latency_data: got %h want %h", m_axis_tdata, {16'd104, 16'd4}); end
            end
        end
        s_axis_tvalid = 1'b0;
        step(3);
        exp_frames += 2;
        n_cmp += 3;
        if (st_total !== 0) begin n_bad++; $display("FAIL smp_stalls: got %0d want 0", st_total); end
        if (out_q.size() !== 2) begin n_bad++; $display("FAIL smp_count: got %0d want 2", out_q.size()); end
        if (sts_frames !== 32'(exp_frames)) begin n_bad++; $display("FAIL smp_sts: got %0d want %0d", sts_frames, exp_frames); end
        if (out_q.size() == 2) begin
            n_cmp += 3;
            if (out_q[0] !== {16'd104, 16'd4}) begin n_bad++; $display("FAIL smp_out0: got %h want %h", out_q[0], {16'd104, 16'd4}); end
            if (out_q[1] !== {16'd108, 16'd8}) begin n_bad++; $display("FAIL smp_out1: got %h want %h", out_q[1], {16'd108, 16'd8}); end
            if (out_t[1] - out_t[0] !== 4) begin n_bad++; $display("FAIL smp_spacing: got %0d want 4", out_t[1] - out_t[0]); end
        end
    endtask

    task automatic test_accum();
        int st;
        cfg_data = 16'd3; cfg_mode = 2'd1; cfg_shift = 5'd2;
        out_q.delete();
        send(16'd10, 16'hFFFC, st);
        send(16'd20, 16'hFFFC, st);
        send(16'd30, 16'hFFFC, st);
        send(16'd40, 16'hFFFC, st);
        s_axis_tvalid = 1'b0;
        step(2);
        exp_frames += 1;
        n_cmp += 2;
        if (out_q.size() !== 1) begin n_bad++; $display("FAIL acc_count: got %0d want 1", out_q.size()); end
        if (out_q.size() > 0 && out_q[0] !== {16'hFFFC, 16'd25}) begin n_bad++; $display("FAIL acc_out: got %h want %h", out_q[0], {16'hFFFC, 16'd25}); end
    endtask

    task automatic test_saturate();
        int st;
        cfg_data = 16'd1; cfg_mode = 2'd1; cfg_shift = 5'd0;
        out_q.delete();
        send(16'h7FFF, 16'd1, st);
        send(16'h7FFF, 16'd2, st);
        send(16'h8000, 16'hFFFF, st);
        send(16'h8000, 16'hFFFF, st);
        s_axis_tvalid = 1'b0;
        step(2);
        exp_frames += 2;
        n_cmp += 3;
        if (out_q.size() !== 2) begin n_bad++; $display("FAIL sat_count: got %0d want 2", out_q.size()); end
        if (out_q.size() > 0 && out_q[0] !== {16'd3, 16'h7FFF}) begin n_bad++; $display("FAIL sat_pos: got %h want %h", out_q[0], {16'd3, 16'h7FFF}); end
        if (out_q.size() > 1 && out_q[1] !== {16'hFFFE, 16'h8000}) begin n_bad++; $display("FAIL sat_neg: got %h want %h", out_q[1], {16'hFFFE, 16'h8000}); end
    endtask

    task automatic test_max();
        int st;
        cfg_data = 16'd2; cfg_mode = 2'd2; cfg_shift = 5'd0;
        out_q.delete();
        send(16'hFFFB, 16'd1, st);
        send(16'd7, 16'd5, st);
        send(16'd3, 16'd2, st);
        send(16'hFFF7, 16'hFFF0, st);
        send(16'hFFFE, 16'hFFF1, st);
        send(16'hFFFA, 16'hFFF2, st);
        s_axis_tvalid = 1'b0;
        step(2);
        exp_frames += 2;
        n_cmp += 3;
        if (out_q.size() !== 2) begin n_bad++; $display("FAIL max_count: got %0d want 2", out_q.size()); end
        if (out_q.size() > 0 && out_q[0] !== {16'd5, 16'd7}) begin n_bad++; $display("FAIL max_pos: got %h want %h", out_q[0], {16'd5, 16'd7}); end
        if (out_q.size() > 1 && out_q[1] !== {16'hFFF2, 16'hFFFE}) begin n_bad++; $display("FAIL max_neg: got %h want %h", out_q[1], {16'hFFF2, 16'hFFFE}); end
    endtask

    task automatic test_backpressure();
        int st;
        cfg_data = 16'd0; cfg_mode = 2'd0; cfg_shift = 5'd0;
        m_axis_tready = 1'b0;
        out_q.delete();
        send(16'h1111, 16'h2222, st);
        s_axis_tdata  = {16'h4444, 16'h3333};
        s_axis_tvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            n_cmp += 3;
            if (m_axis_tvalid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid: got %0b want 1", m_axis_tvalid); end
            if (m_axis_tdata !== {16'h2222, 16'h1111}) begin n_bad++; $display("FAIL bp_hold_data: got %h want %h", m_axis_tdata, {16'h2222, 16'h1111}); end
            if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL bp_tready: got %0b want 0", s_axis_tready); end
            @(posedge aclk);
            #1;
        end
        n_cmp++;
        if (sts_frames !== 32'(exp_frames)) begin n_bad++; $display("FAIL bp_sts_stall: got %0d want %0d", sts_frames, exp_frames); end
        m_axis_tready = 1'b1;
        send(16'h3333, 16'h4444, st);
        n_cmp += 2;
        if (m_axis_tvalid !== 1'b1) begin n_bad++; $display("FAIL bp_nobubble_valid: got %0b want 1", m_axis_tvalid); end
        if (m_axis_tdata !== {16'h4444, 16'h3333}) begin n_bad++; $display("FAIL bp_nobubble_data: got %h want %h", m_axis_tdata, {16'h4444, 16'h3333}); end
        s_axis_tvalid = 1'b0;
        step(2);
        exp_frames += 2;
        n_cmp += 4;
        if (out_q.size() !== 2) begin n_bad++; $display("FAIL bp_count: got %0d want 2", out_q.size()); end
        if (out_q.size() > 0 && out_q[0] !== {16'h2222, 16'h1111}) begin n_bad++; $display("FAIL bp_out0: got %h want %h", out_q[0], {16'h2222, 16'h1111}); end
        if (out_q.size() > 1 && out_q[1] !== {16'h4444, 16'h3333}) begin n_bad++; $display("FAIL bp_out1: got %h want %h", out_q[1], {16'h4444, 16'h3333}); end
        if (sts_frames !== 32'(exp_frames)) begin n_bad++; $display("FAIL bp_sts: got %0d want %0d", sts_frames, exp_frames); end
    endtask

    task automatic test_cfg_change_and_reset();
        int st;
        cfg_data = 16'd3; cfg_mode = 2'd0; cfg_shift = 5'd0;
        m_axis_tready = 1'b1;
        out_q.delete();
        send(16'd1, 16'd0, st);
        cfg_data = 16'd1;
        send(16'd2, 16'd0, st);
        send(16'd3, 16'd0, st);
        send(16'd4, 16'd0, st);
        send(16'd5, 16'd0, st);
        send(16'd6, 16'd0, st);
        s_axis_tvalid = 1'b0;
        step(2);
        exp_frames += 2;
        n_cmp += 4;
        if (out_q.size() !== 2) begin n_bad++; $display("FAIL cfg_count: got %0d want 2", out_q.size()); end
        if (out_q.size() > 0 && out_q[0] !== {16'd0, 16'd4}) begin n_bad++; $display("FAIL cfg_out0: got %h want %h", out_q[0], {16'd0, 16'd4}); end
        if (out_q.size() > 1 && out_q[1] !== {16'd0, 16'd6}) begin n_bad++; $display("FAIL cfg_out1: got %h want %h", out_q[1], {16'd0, 16'd6}); end
        if (sts_frames !== 32'(exp_frames)) begin n_bad++; $display("FAIL cfg_sts: got %0d want %0d", sts_frames, exp_frames); end

        send(16'd7, 16'd0, st);
        s_axis_tvalid = 1'b0;
        aresetn = 1'b0;
        #1;
        n_cmp += 3;
        if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %0b want 0", m_axis_tvalid); end
        if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_tready: got %0b want 0", s_axis_tready); end
        if (sts_frames !== 32'd0) begin n_bad++; $display("FAIL mid_rst_sts: got %0d want 0", sts_frames); end
        step(1);
        aresetn = 1'b1;
        step(1);
        out_q.delete();
        send(16'd10, 16'd0, st);
        send(16'd11, 16'd0, st);
        s_axis_tvalid = 1'b0;
        step(2);
        n_cmp += 3;
        if (out_q.size() !== 1) begin n_bad++; $display("FAIL post_rst_count: got %0d want 1", out_q.size()); end
        if (out_q.size() > 0 && out_q[0] !== {16'd0, 16'd11}) begin n_bad++; $display("FAIL post_rst_out: got %h want %h", out_q[0], {16'd0, 16'd11}); end
        if (sts_frames !== 32'd1) begin n_bad++; $display("FAIL post_rst_sts: got %0d want 1", sts_frames); end
    endtask

    initial begin
        test_reset();
        test_sample();
        test_accum();
        test_saturate();
        test_max();
        test_backpressure();
        test_cfg_change_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
